gp_register_file: RTL
=====================

Name: gp_register_file

Overview:
Parametrised successor to the team's fixed X/Y/accumulator register block. It holds NUM_REGS general registers with one write port and two registered read ports with write-first bypass. It also holds an accumulator that is loaded from memory or from the ALU, and a small LIFO save stack for accumulator context (push/pop). It sits between the control unit, the ALU operand muxes and the memory data path of the GPP.

Parameters:
DATA_W, 16, data width of all registers, accumulator and stack entries
NUM_REGS, 4, number of general registers (min 2)
ADDR_W, $clog2(NUM_REGS), register index width (derived; not overridden)
STK_DEPTH, 4, accumulator save-stack entries (min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
wr_en  in  1  write general register
wr_addr  in  ADDR_W  write index
wr_data  in  DATA_W  write data
rd_en_a  in  1  read request, port A
rd_addr_a  in  ADDR_W  read index A
rd_data_a  out  DATA_W  registered read data A
rd_en_b  in  1  read request, port B
rd_addr_b  in  ADDR_W  read index B
rd_data_b  out  DATA_W  registered read data B
acc_wr_mem  in  1  load accumulator from memory
acc_data_mem  in  DATA_W  memory data
acc_wr_alu  in  1  load accumulator from ALU result
acc_data_alu  in  DATA_W  ALU result
acc_push  in  1  push accumulator onto save stack
acc_pop  in  1  pop save stack into accumulator
err_clr  in  1  clear sticky error flags
acc_out  out  DATA_W  accumulator value
acc_zero  out  1  acc_out == 0
acc_neg  out  1  acc_out[DATA_W-1]
stk_full  out  1  stack count == STK_DEPTH
stk_empty  out  1  stack count == 0
err_ovf  out  1  sticky: push attempted while full
err_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=0, async) clears all registers, accumulator, stack storage, count, rd_data_a/b, err_ovf and err_unf to 0. Outputs after reset: acc_zero=1, acc_neg=0, stk_empty=1, stk_full=0.
- General write: on posedge with wr_en=1 and wr_addr<NUM_REGS, reg[wr_addr] <= wr_data. If wr_addr>=NUM_REGS the write is dropped.
- Read ports are independent and have 1-cycle latency. At posedge, rd_data_x <= (rd_en_x ? value : 0).
  - value is wr_data when wr_en=1 and wr_addr==rd_addr_x (write-first bypass).
  - value is 0 when rd_addr_x>=NUM_REGS.
  - otherwise value is reg[rd_addr_x].
  - Both ports may read the same index in the same cycle.
- Accumulator next-value priority per cycle, highest first:
  1. Valid pop (acc_pop=1, acc_push=0, count>0): acc <= stack[count-1]; count--.
  2. acc_wr_alu: acc <= acc_data_alu.
  3. acc_wr_mem: acc <= acc_data_mem.
  4. Otherwise acc holds.
- Push (acc_push=1, acc_pop=0):
  - If count<STK_DEPTH: stack[count] <= current acc (the pre-edge value); count++.
  - An ALU or memory write in the same cycle still updates acc, so the old value is saved and the new one loaded.
- Push while full: stack and count unchanged, err_ovf <= 1. The accumulator write still proceeds.
- Pop while empty: stack, count and acc-from-pop unchanged, err_unf <= 1. A lower-priority ALU or memory write that cycle still applies.
- acc_push=1 and acc_pop=1 together: no stack operation and no error. The accumulator writes (ALU/memory) proceed.
- err_clr=1 clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- acc_out, acc_zero, acc_neg, stk_full and stk_empty are combinational from the registered state (0-cycle latency from state).
- Stack storage is not cleared on pop; only count defines valid entries.

Decomposition:
- Shared package gpp_pkg holds the defaults GPP_DATA_W=16, GPP_NUM_REGS=4, GPP_STK_DEPTH=4 and the accumulator-source priority encoding (ACC_SRC_HOLD, ACC_SRC_MEM, ACC_SRC_ALU, ACC_SRC_POP).
- One sub-module is natural: gpp_acc_stack (LIFO with count, full/empty, overflow/underflow detection). The top level instantiates it and owns the register array, read ports and accumulator mux.

Test Plan:
- Reset mid-operation: write reg1=16'hA5A5, assert rst=0 between clock edges -> all outputs clear immediately; after release, reading reg1 gives 0, stk_empty=1, acc_zero=1.
- Write/read/bypass: wr reg2=16'h5A5A while rd_en_a=1, rd_addr_a=2 in the same cycle -> rd_data_a=16'h5A5A next cycle. rd_en_b=0 -> rd_data_b=0. Out-of-range rd_addr (NUM_REGS=3 build, addr 3) -> 0.
- Accumulator priority: acc_wr_mem=1 (16'h1234) and acc_wr_alu=1 (16'hBEEF) together -> acc_out=16'hBEEF, acc_neg=1.
- Push with load: acc=16'h0011, push + acc_wr_mem=16'h0022 -> top=16'h0011, acc=16'h0022. Pop -> acc=16'h0011, stk_empty=1.
- Stack limits: 4 pushes -> stk_full=1; 5th push -> err_ovf=1, count stays 4. Pop on empty with acc_wr_alu=16'h0007 -> err_unf=1, acc=16'h0007. err_clr -> both flags 0.
- Push+pop together with 2 entries -> count stays 2, acc unchanged, no error flag.

Source files
------------

// File: rtl/gpp_pkg.sv
// Shared definitions for the GPP register file slice:
// default widths and the accumulator source priority encoding.
package gpp_pkg;

    localparam int GPP_DATA_W    = 16;
    localparam int GPP_NUM_REGS  = 4;
    localparam int GPP_STK_DEPTH = 4;

    typedef enum logic [1:0] {
        ACC_SRC_HOLD = 2'd0,
        ACC_SRC_MEM  = 2'd1,
        ACC_SRC_ALU  = 2'd2,
        ACC_SRC_POP  = 2'd3
    } acc_src_e;

    // Pop beats ALU beats memory; nothing selected means hold.
    function automatic acc_src_e acc_src_sel(
        input logic pop_ok,
        input logic alu,
        input logic mem
    );
        acc_src_e s;
        s = ACC_SRC_HOLD;
        if (pop_ok)   s = ACC_SRC_POP;
        else if (alu) s = ACC_SRC_ALU;
        else if (mem) s = ACC_SRC_MEM;
        return s;
    endfunction

endpackage

// File: rtl/gpp_acc_stack.sv
// Accumulator save stack: LIFO with count, full/empty
// and sticky overflow/underflow detection.
module gpp_acc_stack
    import gpp_pkg::*;
#(
    parameter int DATA_W    = GPP_DATA_W,
    parameter int STK_DEPTH = GPP_STK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_err_clr,
    input  logic [DATA_W-1:0] i_push_data,
    output logic [DATA_W-1:0] o_top_data,
    output logic              o_pop_ok,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_err_ovf,
    output logic              o_err_unf
);

    localparam int CNT_W = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [STK_DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_err_ovf;
    logic              r_err_unf;

    logic [CNT_W-1:0]  w_cnt_m1;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_push_only;
    logic              w_pop_only;
    logic              w_do_push;
    logic              w_do_pop;
    logic              w_ovf;
    logic              w_unf;

    assign o_full  = (r_count == CNT_W'(STK_DEPTH));
    assign o_empty = (r_count == '0);

    // Simultaneous push and pop cancel: no stack op, no error.
    assign w_push_only = i_push & ~i_pop;
    assign w_pop_only  = i_pop & ~i_push;
    assign w_do_push   = w_push_only & ~o_full;
    assign w_do_pop    = w_pop_only & ~o_empty;
    assign w_ovf       = w_push_only & o_full;
    assign w_unf       = w_pop_only & o_empty;

    assign w_cnt_m1   = r_count - CNT_W'(1);
    assign w_top_idx  = w_cnt_m1[IDX_W-1:0];
    assign w_wr_idx   = r_count[IDX_W-1:0];
    assign o_top_data = r_mem[w_top_idx];
    assign o_pop_ok   = w_do_pop;
    assign o_err_ovf  = r_err_ovf;
    assign o_err_unf  = r_err_unf;

    // Entry storage; popped entries are left in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STK_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    // Occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_count <= '0;
        else if (w_do_push)
            r_count <= r_count + CNT_W'(1);
        else if (w_do_pop)
            r_count <= w_cnt_m1;
    end

    // Sticky error flags; a new error beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_ovf)          r_err_ovf <= 1'b1;
            else if (i_err_clr) r_err_ovf <= 1'b0;
            if (w_unf)          r_err_unf <= 1'b1;
            else if (i_err_clr) r_err_unf <= 1'b0;
        end
    end

endmodule

// File: rtl/gp_register_file.sv
// GPP general register file: NUM_REGS registers, two registered
// read ports with write-first bypass, accumulator and save stack.
module gp_register_file
    import gpp_pkg::*;
#(
    parameter int DATA_W    = GPP_DATA_W,
    parameter int NUM_REGS  = GPP_NUM_REGS,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int STK_DEPTH = GPP_STK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              acc_wr_mem,
    input  logic [DATA_W-1:0] acc_data_mem,
    input  logic              acc_wr_alu,
    input  logic [DATA_W-1:0] acc_data_alu,
    input  logic              acc_push,
    input  logic              acc_pop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_zero,
    output logic              acc_neg,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              err_ovf,
    output logic              err_unf
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;
    logic [DATA_W-1:0] r_acc;

    logic              w_wr_ok;
    logic              w_in_a;
    logic              w_in_b;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;
    logic [DATA_W-1:0] w_top;
    logic              w_pop_ok;
    acc_src_e          w_src;

    // Writes to indices beyond the array are dropped.
    assign w_wr_ok = wr_en && (int'(wr_addr) < NUM_REGS);
    assign w_in_a  = int'(rd_addr_a) < NUM_REGS;
    assign w_in_b  = int'(rd_addr_b) < NUM_REGS;

    // Port A source: bypassed write data, stored value, or 0.
    always_comb begin
        w_val_a = '0;
        if (w_in_a)
            w_val_a = (w_wr_ok && wr_addr == rd_addr_a)
                    ? wr_data : r_regs[rd_addr_a];
    end

    // Port B source: same rules as port A.
    always_comb begin
        w_val_b = '0;
        if (w_in_b)
            w_val_b = (w_wr_ok && wr_addr == rd_addr_b)
                    ? wr_data : r_regs[rd_addr_b];
    end

    // General register array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Registered read ports; a disabled port returns 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            r_rd_a <= rd_en_a ? w_val_a : '0;
            r_rd_b <= rd_en_b ? w_val_b : '0;
        end
    end

    gpp_acc_stack #(
        .DATA_W    (DATA_W),
        .STK_DEPTH (STK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .i_push      (acc_push),
        .i_pop       (acc_pop),
        .i_err_clr   (err_clr),
        .i_push_data (r_acc),
        .o_top_data  (w_top),
        .o_pop_ok    (w_pop_ok),
        .o_full      (stk_full),
        .o_empty     (stk_empty),
        .o_err_ovf   (err_ovf),
        .o_err_unf   (err_unf)
    );

    assign w_src = acc_src_sel(w_pop_ok, acc_wr_alu, acc_wr_mem);

    // Accumulator load by priority: pop, ALU, memory, hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else begin
            unique case (w_src)
                ACC_SRC_POP:  r_acc <= w_top;
                ACC_SRC_ALU:  r_acc <= acc_data_alu;
                ACC_SRC_MEM:  r_acc <= acc_data_mem;
                default:      r_acc <= r_acc;
            endcase
        end
    end

    assign rd_data_a = r_rd_a;
    assign rd_data_b = r_rd_b;
    assign acc_out   = r_acc;
    assign acc_zero  = (r_acc == '0);
    assign acc_neg   = r_acc[DATA_W-1];

endmodule
